// File: rtl/cache_fill_if.sv
// Fill-side bus between the cache and its miss-handling controller.
// Carries the miss request from the cache, the pipelined main-memory read
// request/return, and the controller's write strobes and index back into the cache.
//   master : the fill controller (issues memory reads, drives cache writes)
//   slave  : the cache/memory side
interface cache_fill_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_read_addr;
  logic              fsm_busy;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid,
    output mem_read_en, mem_read_addr, fsm_busy, memory_address,
           write_data_array, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid,
    input  mem_read_en, mem_read_addr, fsm_busy, memory_address,
           write_data_array, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller. On a miss it issues BLOCK_WORDS back-to-back
// reads to pipelined main memory, writes each returning word into the data
// array in order, then pulses the tag write for one cycle.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : cache_fill_if.master (miss in, memory read out/return in,
//          cache write strobes and index out)
//
// state | meaning
// IDLE  | waiting for a miss; outputs quiet
// FILL  | issuing reads and accepting returned words
// TAG   | one-cycle tag/valid write for the filled block
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  cache_fill_if.master  bus
);

  localparam int CW    = $clog2(BLOCK_WORDS);
  localparam int OFF_W = $clog2(BLOCK_WORDS * WORD_BYTES);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     issue_cnt, rcv_cnt;
  logic              issue_done;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] issue_addr, rcv_addr;
  logic              capture, issue_fire, rcv_fire;

  assign issue_addr = base + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES);
  assign rcv_addr   = base + ADDR_W'(rcv_cnt) * ADDR_W'(WORD_BYTES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    capture              = 1'b0;
    issue_fire           = 1'b0;
    rcv_fire             = 1'b0;
    bus.mem_read_en      = 1'b0;
    bus.mem_read_addr    = '0;
    bus.fsm_busy         = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) begin
          capture   = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        bus.fsm_busy       = 1'b1;
        // index stays on the next expected word even when nothing returns
        bus.memory_address = rcv_addr;
        if (!issue_done) begin
          issue_fire        = 1'b1;
          bus.mem_read_en   = 1'b1;
          bus.mem_read_addr = issue_addr;
        end
        if (bus.memory_data_valid) begin
          rcv_fire             = 1'b1;
          bus.write_data_array = 1'b1;
          if (rcv_cnt == LAST) state_nxt = TAG;
        end
      end
      TAG: begin
        bus.write_tag_array = 1'b1;
        bus.memory_address  = base;
        state_nxt           = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // issue_done distinguishes "all issued" from the 3-bit counter wrapping to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      issue_done <= 1'b0;
      base       <= '0;
    end else if (capture) begin
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      issue_done <= 1'b0;
      base       <= {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end else begin
      if (issue_fire) begin
        issue_cnt <= issue_cnt + 1'b1;
        if (issue_cnt == LAST) issue_done <= 1'b1;
      end
      if (rcv_fire) rcv_cnt <= rcv_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_fill_if #(.ADDR_W(16)) bus();
  cache_fill_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // stimulus settings
  logic        rst_d = 1'b0;
  logic        miss_d = 1'b0;
  logic [15:0] addr_d = '0;
  int          lat = 1;
  int          vpct = 100;
  bit          alt = 0;
  int          spur_pct = 0;

  // pending memory returns: cycle at which each becomes available
  int mem_q[$];

  // behavioural model of the fill
  bit          m_active = 0;
  bit          m_tag = 0;
  int          m_issued = 0;
  int          m_rcvd = 0;
  logic [15:0] m_base = '0;

  logic [15:0] rd_log[$];
  int          rd_cyc[$];
  logic [15:0] wr_log[$];
  int          tag_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit v;
    logic        e_en, e_busy, e_wda, e_tag;
    logic [15:0] e_ra, e_ma;
    @(posedge clk); #1;
    cyc++;
    v = 0;
    if (mem_q.size() > 0 && mem_q[0] <= cyc && $urandom_range(99) < vpct && (!alt || cyc[0])) begin
      v = 1;
      void'(mem_q.pop_front());
    end else if (!m_active && mem_q.size() == 0 && $urandom_range(99) < spur_pct) begin
      v = 1;
    end
    bus.memory_data_valid = v;
    bus.miss_detected     = miss_d;
    bus.miss_address      = addr_d;
    rst                   = rst_d;
    @(negedge clk);
    e_en = 0; e_busy = 0; e_wda = 0; e_tag = 0; e_ra = '0; e_ma = '0;
    if (!rst) begin
      m_active = 0; m_tag = 0; m_base = '0;
    end else if (m_tag) begin
      e_tag = 1; e_ma = m_base; m_tag = 0;
    end else if (m_active) begin
      e_busy = 1;
      e_ma = 16'(m_base + 2 * m_rcvd);
      if (m_issued < 8) begin
        e_en = 1; e_ra = 16'(m_base + 2 * m_issued); m_issued++;
      end
      if (v) begin
        e_wda = 1; m_rcvd++;
        if (m_rcvd == 8) begin m_active = 0; m_tag = 1; end
      end
    end else if (miss_d) begin
      m_base = addr_d & 16'hFFF0; m_active = 1; m_issued = 0; m_rcvd = 0;
    end
    chk("mem_read_en", {31'b0, bus.mem_read_en}, {31'b0, e_en});
    chk("mem_read_addr", {16'b0, bus.mem_read_addr}, {16'b0, e_ra});
    chk("fsm_busy", {31'b0, bus.fsm_busy}, {31'b0, e_busy});
    chk("memory_address", {16'b0, bus.memory_address}, {16'b0, e_ma});
    chk("write_data_array", {31'b0, bus.write_data_array}, {31'b0, e_wda});
    chk("write_tag_array", {31'b0, bus.write_tag_array}, {31'b0, e_tag});
    if (bus.mem_read_en) begin
      mem_q.push_back(cyc + lat);
      rd_log.push_back(bus.mem_read_addr);
      rd_cyc.push_back(cyc);
    end
    if (bus.write_data_array) wr_log.push_back(bus.memory_address);
    if (bus.write_tag_array) tag_cnt++;
  endtask

  task automatic clear_logs();
    rd_log.delete(); rd_cyc.delete(); wr_log.delete(); tag_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((m_active || m_tag) && n < budget) begin step(); n++; end
    if (n >= budget) chk("fill_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic drain();
    int n = 0;
    while (mem_q.size() > 0 && n < 200) begin step(); n++; end
    if (n >= 200) chk("drain_timeout", 32'(mem_q.size()), 0);
  endtask

  task automatic run_fill(input logic [15:0] a, input int l, input int pct, input bit hold);
    lat = l; vpct = pct; addr_d = a; miss_d = 1;
    step();
    if (!hold) miss_d = 0;
    wait_done(400);
  endtask

  task automatic chk_block(input string name, input logic [15:0] q[$], input logic [15:0] base);
    chk({name, "_count"}, 32'(q.size()), 8);
    for (int i = 0; i < q.size() && i < 8; i++)
      chk(name, {16'b0, q[i]}, {16'b0, 16'(base + 2 * i)});
  endtask

  initial begin
    bus.miss_detected = 0; bus.miss_address = '0; bus.memory_data_valid = 0;
    rst_d = 0;
    repeat (3) step();
    rst_d = 1;
    repeat (2) step();

    // reset mid-fill after 3 returns; late returns must be ignored
    lat = 1; vpct = 100; addr_d = 16'h5550; miss_d = 1;
    step(); miss_d = 0;
    for (int n = 0; n < 50 && m_rcvd < 3; n++) step();
    chk("rcvd_before_reset", 32'(m_rcvd), 3);
    rst_d = 0;
    step();
    chk("reset_busy_now", {31'b0, bus.fsm_busy}, 0);
    chk("reset_rden_now", {31'b0, bus.mem_read_en}, 0);
    step();
    rst_d = 1;
    clear_logs();
    drain();
    repeat (3) step();
    chk("late_return_writes", 32'(wr_log.size()), 0);

    // aligned fill, latency 4
    clear_logs();
    run_fill(16'h1236, 4, 100, 0);
    chk_block("t2_rd", rd_log, 16'h1230);
    chk_block("t2_wr", wr_log, 16'h1230);
    if (rd_cyc.size() == 8) chk("t2_rd_consecutive", 32'(rd_cyc[7] - rd_cyc[0]), 7);
    chk("t2_tag", 32'(tag_cnt), 1);
    drain(); step();

    // bubbly memory: valid only on alternate cycles
    clear_logs();
    alt = 1;
    run_fill(16'h4A5C, 2, 100, 0);
    alt = 0;
    chk_block("t3_wr", wr_log, 16'h4A50);
    chk("t3_tag", 32'(tag_cnt), 1);
    drain(); step();

    // miss held through FILL/TAG with a new address
    clear_logs();
    lat = 3; vpct = 100; addr_d = 16'h2222; miss_d = 1;
    step();
    addr_d = 16'hABCD;
    wait_done(400);
    chk_block("t4_first_rd", rd_log, 16'h2220);
    clear_logs();
    step();
    miss_d = 0;
    wait_done(400);
    chk_block("t4_second_rd", rd_log, 16'hABC0);
    drain(); step();

    // spurious valids in IDLE and in TAG
    clear_logs();
    spur_pct = 100;
    repeat (6) step();
    chk("t5_idle_writes", 32'(wr_log.size()), 0);
    run_fill(16'h7770, 2, 100, 0);
    chk("t5_fill_writes", 32'(wr_log.size()), 8);
    repeat (3) step();
    chk("t5_after_writes", 32'(wr_log.size()), 8);
    spur_pct = 0;
    drain(); step();

    // top of address space
    clear_logs();
    run_fill(16'hFFFE, 1, 100, 0);
    chk_block("t6_rd", rd_log, 16'hFFF0);
    chk_block("t6_wr", wr_log, 16'hFFF0);
    drain(); step();

    // randomized fills
    for (int t = 0; t < 25; t++) begin
      spur_pct = 25;
      lat = 1 + $urandom_range(5);
      vpct = 30 + $urandom_range(70);
      addr_d = 16'($urandom);
      miss_d = 1;
      step();
      if ($urandom_range(1) == 0) miss_d = 0;
      addr_d = 16'($urandom);
      if ($urandom_range(5) == 0) begin
        for (int n = 0; n < 40 && m_active && m_rcvd < 5; n++) step();
        rst_d = 0;
        repeat (1 + $urandom_range(2)) step();
        rst_d = 1;
      end else begin
        wait_done(400);
      end
      miss_d = 0;
      spur_pct = 0;
      wait_done(400);
      drain();
      repeat ($urandom_range(3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
